// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and result return channels of alu_seq.
// The master side is the operand source and result sink; the slave side is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 err;
    logic [3:0]           flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, err, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, err, flags
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU. Accepts one operation per transaction
// over valid/ready, returns a registered 2*WIDTH-bit result plus err.
// Single-cycle ops (including MUL) finish with latency 1; DIV runs a
// WIDTH-iteration restoring divider, one quotient bit per cycle, MSB first.
// Optional feature macro: ALU_FLAGS_EN -- when defined, {N,V,C,Z} flags are
// registered with the result; otherwise the flags port is tied to zero.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_MUL     = 4'd2,
        OP_DIV     = 4'd3,
        OP_AND     = 4'd4,
        OP_OR      = 4'd5,
        OP_NAND    = 4'd6,
        OP_NOR     = 4'd7,
        OP_XOR     = 4'd8,
        OP_XNOR    = 4'd9,
        OP_EQ      = 4'd10,
        OP_GT      = 4'd11,
        OP_LT      = 4'd12,
        OP_SHR     = 4'd13,
        OP_SHL     = 4'd14,
        OP_ILLEGAL = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [WIDTH:0] WIDTH_V = WIDTH;

    state_e                r_state;
    state_e                w_state_next;
    logic                  w_accept;
    logic                  w_start_div;
    logic                  w_div_last;

    logic [WIDTH-1:0]      r_b;
    logic [WIDTH-1:0]      r_rem;
    logic [WIDTH-1:0]      r_quo;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*WIDTH-1:0]    r_result;
    logic                  r_err;

    alu_op_e               w_op;
    logic [2*WIDTH-1:0]    w_single;
    logic                  w_single_err;

    logic [WIDTH:0]        w_trial;
    logic [WIDTH:0]        w_diff;
    logic [WIDTH-1:0]      w_rem_next;
    logic [WIDTH-1:0]      w_quo_next;

    assign w_op          = alu_op_e'(bus.op);
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.result    = r_result;
    assign bus.err       = r_err;

    // State register for the IDLE/BUSY/HOLD handshake controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate in BUSY, wait for the sink in HOLD.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_start_div  = 1'b0;
        w_div_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if ((w_op == OP_DIV) && (bus.b != '0)) begin
                        w_start_div  = 1'b1;
                        w_state_next = BUSY;
                    end else begin
                        w_state_next = HOLD;
                    end
                end
            end
            BUSY: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_div_last   = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Single-cycle result for every opcode, computed straight from the bus operands.
    always_comb begin
        w_single     = '0;
        w_single_err = 1'b0;
        case (w_op)
            OP_ADD:  w_single = {{(WIDTH-1){1'b0}}, {1'b0, bus.a} + {1'b0, bus.b}};
            OP_SUB:  w_single = {{(WIDTH-1){1'b0}}, {1'b0, bus.a} - {1'b0, bus.b}};
            OP_MUL:  w_single = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
            OP_DIV: begin
                w_single     = '1;
                w_single_err = 1'b1;
            end
            OP_AND:  w_single = {{WIDTH{1'b0}}, bus.a & bus.b};
            OP_OR:   w_single = {{WIDTH{1'b0}}, bus.a | bus.b};
            OP_NAND: w_single = {{WIDTH{1'b0}}, ~(bus.a & bus.b)};
            OP_NOR:  w_single = {{WIDTH{1'b0}}, ~(bus.a | bus.b)};
            OP_XOR:  w_single = {{WIDTH{1'b0}}, bus.a ^ bus.b};
            OP_XNOR: w_single = {{WIDTH{1'b0}}, ~(bus.a ^ bus.b)};
            OP_EQ:   w_single = {{(2*WIDTH-1){1'b0}}, bus.a == bus.b};
            OP_GT:   w_single = {{(2*WIDTH-1){1'b0}}, bus.a > bus.b};
            OP_LT:   w_single = {{(2*WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_SHR: begin
                if ({1'b0, bus.b} < WIDTH_V) begin
                    w_single = {{WIDTH{1'b0}}, bus.a >> bus.b};
                end
            end
            OP_SHL: begin
                if ({1'b0, bus.b} < WIDTH_V) begin
                    w_single = {{WIDTH{1'b0}}, bus.a << bus.b};
                end
            end
            OP_ILLEGAL: begin
                w_single     = '0;
                w_single_err = 1'b1;
            end
            default: begin
                w_single     = '0;
                w_single_err = 1'b1;
            end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_trial    = {r_rem, r_quo[WIDTH-1]};
        w_diff     = w_trial - {1'b0, r_b};
        w_rem_next = w_trial[WIDTH-1:0];
        w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
        if (!w_diff[WIDTH]) begin
            w_rem_next = w_diff[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
        end
    end

    // Datapath: capture operands on accept, iterate the divider, hold the result in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_b   <= bus.b;
            r_rem <= '0;
            r_quo <= bus.a;
            if (w_start_div) begin
                r_cnt <= CNT_W'(WIDTH);
            end else begin
                r_result <= w_single;
                r_err    <= w_single_err;
            end
        end else if (r_state == BUSY) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_div_last) begin
                r_result <= {w_rem_next, w_quo_next};
                r_err    <= 1'b0;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] r_flags;

    // {N,V,C,Z} derived from the opcode and the result about to be registered.
    function automatic logic [3:0] calcFlags(input alu_op_e op, input logic [2*WIDTH-1:0] res);
        logic fN, fV, fC, fZ;
        fZ = (res == '0);
        fC = ((op == OP_ADD) || (op == OP_SUB)) ? res[WIDTH] : 1'b0;
        fV = (op == OP_MUL) ? (res[2*WIDTH-1:WIDTH] != '0) : 1'b0;
        fN = res[WIDTH-1];
        return {fN, fV, fC, fZ};
    endfunction

    // Flags register, updated in the same cycles as the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_accept && !w_start_div) begin
            r_flags <= calcFlags(w_op, w_single);
        end else if ((r_state == BUSY) && w_div_last) begin
            r_flags <= calcFlags(OP_DIV, {w_rem_next, w_quo_next});
        end
    end

    assign bus.flags = r_flags;
`else
    assign bus.flags = 4'b0000;
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational ALU opcode set (alu_op_e, 4-bit).
- Accepts one operation per transaction over a valid/ready interface and returns a registered 2*WIDTH-bit result.
- MUL and all single-cycle ops complete in 1 cycle. DIV is a WIDTH-cycle iterative restoring divider.
- Sits between the UART frame decoder (operand/opcode source) and the UART transmit path (result sink).

Parameters:
- WIDTH, 8, operand width in bits (>=2, power of two).
- CNT_W, $clog2(WIDTH)+1, width of the divide iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation.
- op  in  4  alu_op_e opcode.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- result  out  2*WIDTH  operation result.
- err  out  1  divide-by-zero or illegal opcode; valid with out_valid.
- flags  out  4  {N,V,C,Z}; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; result=0; err=0; flags=0; counter=0.
  - A reset mid-DIV abandons the operation; no result is emitted.
- States: IDLE, BUSY, HOLD.
  - IDLE: in_ready=1.
    - On in_valid: capture op, a, b.
    - Non-DIV, or DIV with b==0: compute result, go to HOLD. out_valid=1 on the next cycle (latency 1).
    - DIV with b!=0: go to BUSY, counter=WIDTH.
  - BUSY: in_ready=0. One quotient bit per cycle, MSB first. counter decrements each cycle. When counter reaches 0, go to HOLD. Accept-to-out_valid latency is WIDTH+1 cycles.
  - HOLD: out_valid=1, in_ready=0.
    - result, err and flags are held stable while out_ready=0.
    - On out_ready=1: go to IDLE and drop out_valid the next cycle. No same-cycle re-accept.
- Result mapping (all unsigned; upper WIDTH bits are 0 unless stated):
  - ADD: {carry, a+b}, zero-extended.
  - SUB: (a-b) mod 2^WIDTH in the low half; bit WIDTH=borrow.
  - MUL: full 2*WIDTH-bit product.
  - DIV: {remainder, quotient}. If b==0: result=all ones, err=1.
  - AND/OR/NAND/NOR/XOR/XNOR: bitwise on the low half.
  - EQ/GT/LT: result=1 if true, else 0.
  - SHR/SHL: logical shift of a by b. If b>=WIDTH, result=0.
  - Opcode 4'b1111: result=0, err=1.
- err=0 for every legal operation except DIV by zero.
- in_valid while in_ready=0 is ignored. Inputs are not sampled outside an IDLE accept.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: flags is registered alongside result.
  - Z=(result==0).
  - C=result[WIDTH] for ADD/SUB, else 0.
  - V=1 for MUL when the product does not fit in WIDTH bits, else 0.
  - N=result[WIDTH-1].
- Undefined: flags is tied to 4'b0000 and no flag logic is synthesised. The port remains present.

Test Plan (WIDTH=8):
- ADD a=0xFF, b=0x01 -> out_valid 1 cycle after accept; result=0x0100, err=0; with ALU_FLAGS_EN, flags C=1, Z=0.
- MUL a=0xFF, b=0xFF -> result=0xFE01 after 1 cycle; with ALU_FLAGS_EN, V=1.
- DIV a=200, b=7 -> out_valid 9 cycles after accept; result=0x041C (remainder 4, quotient 28); in_ready=0 throughout.
- DIV a=0x55, b=0 -> result=0xFFFF, err=1, latency 1. Follow with op=4'b1111 -> result=0x0000, err=1.
- Backpressure: SHL a=0x81, b=1 with out_ready=0 for 5 cycles -> result=0x0002 held stable, in_ready=0; accepted on out_ready=1, then in_ready=1 the next cycle.
- Reset mid-DIV: assert rst_n=0 at BUSY cycle 4 -> out_valid=0, result=0, in_ready=1 immediately; no stale result after release.
